// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared defaults, state type and saturating adder for the systolic PE
package systolic_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;
    localparam int K_LEN_DEF  = 16;

    typedef enum logic [1:0] {IDLE, ACC, DONE} pe_state_t;

    // Returns {clamped, value}: a + b limited to 2^width - 1 (width <= 64).
    function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [64:0] max_v;
        sum   = {1'b0, a} + {1'b0, b};
        max_v = (65'd1 << width) - 65'd1;
        if (sum > max_v) begin
            return {1'b1, max_v[63:0]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/systolic_pe_if.sv
// rtl/systolic_pe_if.sv - operand/result bundle of the PE; SAT exists only with SYSTOLIC_PE_SATURATE_EN
interface systolic_pe_if
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);
    logic [DATA_W-1:0] A_in;
    logic [DATA_W-1:0] B_in;
    logic              valid_in;
    logic              clear;
    logic [DATA_W-1:0] A_out;
    logic [DATA_W-1:0] B_out;
    logic              valid_out;
    logic [ACC_W-1:0]  RES;
    logic              res_valid;
    logic              res_ready;
    logic              OVF;
`ifdef SYSTOLIC_PE_SATURATE_EN
    logic              SAT;

    modport slave  (input  A_in, B_in, valid_in, clear, res_ready,
                    output A_out, B_out, valid_out, RES, res_valid, OVF, SAT);
    modport master (output A_in, B_in, valid_in, clear, res_ready,
                    input  A_out, B_out, valid_out, RES, res_valid, OVF, SAT);
`else
    modport slave  (input  A_in, B_in, valid_in, clear, res_ready,
                    output A_out, B_out, valid_out, RES, res_valid, OVF);
    modport master (output A_in, B_in, valid_in, clear, res_ready,
                    input  A_out, B_out, valid_out, RES, res_valid, OVF);
`endif
endinterface

// File: rtl/Bam_cell.sv
// rtl/Bam_cell.sv - multiplier cell: partial product a&b added to incoming sum and carry
module Bam_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic sum_i,
    input  logic carry_i,
    output logic sum_o,
    output logic carry_o
);
    logic pp;

    assign pp      = a_i & b_i;
    assign sum_o   = pp ^ sum_i ^ carry_i;
    assign carry_o = (pp & sum_i) | (pp & carry_i) | (sum_i & carry_i);
endmodule

// File: rtl/array_multiplier.sv
// rtl/array_multiplier.sv - unsigned carry-save array multiplier of Bam_cell with a final ripple row
module array_multiplier
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic [2*DATA_W-1:0] p_o
);
    // Row i adds a*b[i]; sums shift one column right per row, carries stay in column.
    for (genvar i = 0; i < DATA_W; i++) begin : g_row
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] c;
        for (genvar j = 0; j < DATA_W; j++) begin : g_col
            logic sin;
            logic cin;
            if (i == 0) begin : g_top
                assign sin = 1'b0;
                assign cin = 1'b0;
            end else begin : g_inner
                if (j == DATA_W - 1) begin : g_edge
                    assign sin = 1'b0;
                end else begin : g_shift
                    assign sin = g_row[i-1].s[j+1];
                end
                assign cin = g_row[i-1].c[j];
            end
            Bam_cell u_cell (
                .a_i    (a_i[j]),
                .b_i    (b_i[i]),
                .sum_i  (sin),
                .carry_i(cin),
                .sum_o  (s[j]),
                .carry_o(c[j])
            );
        end
        assign p_o[i] = s[0];
    end

    // Ripple row resolves the leftover sum/carry vectors into the upper product half.
    for (genvar j = 0; j < DATA_W; j++) begin : g_fin
        logic rc_in;
        if (j == 0) begin : g_first
            assign rc_in = 1'b0;
        end else begin : g_chain
            assign rc_in = g_fin[j-1].g_cell.rc_out;
        end
        if (j == DATA_W - 1) begin : g_msb
            // Top bit: no shifted sum remains and the product cannot carry out of 2*DATA_W bits.
            assign p_o[2*DATA_W-1] = g_row[DATA_W-1].c[j] ^ rc_in;
        end else begin : g_cell
            logic rc_out;
            Bam_cell u_cell (
                .a_i    (g_row[DATA_W-1].s[j+1]),
                .b_i    (1'b1),
                .sum_i  (g_row[DATA_W-1].c[j]),
                .carry_i(rc_in),
                .sum_o  (p_o[DATA_W+j]),
                .carry_o(rc_out)
            );
        end
    end
endmodule

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - output-stationary PE: forward A/B, multiply-accumulate K_LEN beats, SYSTOLIC_PE_SATURATE_EN clamps
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int K_LEN  = K_LEN_DEF
) (
    input  logic         clk,
    input  logic         rst,
    systolic_pe_if.slave pe
);
    localparam int                CNT_W    = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(K_LEN - 1);

    logic [DATA_W-1:0]   a_fwd_q;
    logic [DATA_W-1:0]   b_fwd_q;
    logic                vld_fwd_q;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    p_q;
    logic                p_valid_q;
    pe_state_t           state_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    sum_d;
    logic [CNT_W-1:0]    count_q;
    logic [ACC_W-1:0]    fin_q;
    logic [ACC_W-1:0]    res_q;
    logic                res_valid_q;
    logic                ovf_q;

    array_multiplier #(.DATA_W(DATA_W)) u_mult (
        .a_i(pe.A_in),
        .b_i(pe.B_in),
        .p_o(prod)
    );

`ifdef SYSTOLIC_PE_SATURATE_EN
    logic        sat_hit;
    logic        sat_run_q;
    logic        fin_sat_q;
    logic        sat_q;
    logic [64:0] sat_res;

    // Clamping accumulate adder; sat_hit marks a clamp on this beat.
    always_comb begin
        sat_res = sat_add(64'(acc_q), 64'(p_q), ACC_W);
        sum_d   = sat_res[ACC_W-1:0];
        sat_hit = sat_res[64];
    end
`else
    // Wrapping accumulate adder (modulo 2^ACC_W).
    always_comb begin
        sum_d = acc_q + p_q;
    end
`endif

    // Neighbour forwarding: plain one-cycle delay, independent of everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_fwd_q   <= '0;
            b_fwd_q   <= '0;
            vld_fwd_q <= 1'b0;
        end else begin
            a_fwd_q   <= pe.A_in;
            b_fwd_q   <= pe.B_in;
            vld_fwd_q <= pe.valid_in;
        end
    end

    // Stage 1: register the product; clear kills a beat entering the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q       <= '0;
            p_valid_q <= 1'b0;
        end else begin
            p_valid_q <= pe.valid_in & ~pe.clear;
            if (pe.valid_in) begin
                p_q <= ACC_W'(prod);
            end
        end
    end

    // Stage 2 FSM: accumulate; the K_LEN-th product parks its total in fin_q and restarts.
    // acc_q is already zero in IDLE and DONE, so acc_q + P covers the restart case too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            count_q   <= '0;
            fin_q     <= '0;
`ifdef SYSTOLIC_PE_SATURATE_EN
            sat_run_q <= 1'b0;
            fin_sat_q <= 1'b0;
`endif
        end else if (pe.clear) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            count_q   <= '0;
`ifdef SYSTOLIC_PE_SATURATE_EN
            sat_run_q <= 1'b0;
`endif
        end else if (p_valid_q) begin
            if (count_q == LAST_CNT) begin
                state_q   <= DONE;
                fin_q     <= sum_d;
                acc_q     <= '0;
                count_q   <= '0;
`ifdef SYSTOLIC_PE_SATURATE_EN
                fin_sat_q <= sat_run_q | sat_hit;
                sat_run_q <= 1'b0;
`endif
            end else begin
                state_q   <= ACC;
                acc_q     <= sum_d;
                count_q   <= count_q + CNT_W'(1);
`ifdef SYSTOLIC_PE_SATURATE_EN
                sat_run_q <= sat_run_q | sat_hit;
`endif
            end
        end else if (state_q == DONE) begin
            state_q <= IDLE;
        end
    end

    // Result port: publish in the DONE cycle so RES and res_valid change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q       <= '0;
            res_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef SYSTOLIC_PE_SATURATE_EN
            sat_q       <= 1'b0;
`endif
        end else if (state_q == DONE) begin
            res_q       <= fin_q;
            res_valid_q <= 1'b1;
            if (res_valid_q && !pe.res_ready) begin
                ovf_q <= 1'b1;
            end
`ifdef SYSTOLIC_PE_SATURATE_EN
            sat_q       <= fin_sat_q;
`endif
        end else if (res_valid_q && pe.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign pe.A_out     = a_fwd_q;
    assign pe.B_out     = b_fwd_q;
    assign pe.valid_out = vld_fwd_q;
    assign pe.RES       = res_q;
    assign pe.res_valid = res_valid_q;
    assign pe.OVF       = ovf_q;
`ifdef SYSTOLIC_PE_SATURATE_EN
    assign pe.SAT       = sat_q;
`endif
endmodule

// File: tb/tb_systolic_pe.sv
// tb/tb_systolic_pe.sv - directed self-checking bench for systolic_pe
module tb_systolic_pe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    systolic_pe_if #(.DATA_W(8), .ACC_W(32)) bus ();
    systolic_pe #(.DATA_W(8), .ACC_W(32), .K_LEN(4)) dut (.clk(clk), .rst(rst), .pe(bus));

    systolic_pe_if #(.DATA_W(8), .ACC_W(16)) bus2 ();
    systolic_pe #(.DATA_W(8), .ACC_W(16), .K_LEN(2)) dut2 (.clk(clk), .rst(rst), .pe(bus2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b);
        bus.A_in     = a;
        bus.B_in     = b;
        bus.valid_in = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_result(input int limit, inout int cyc);
        while (bus.res_valid !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        bus.A_in = '0;  bus.B_in = '0;  bus.valid_in = 1'b0;  bus.clear = 1'b0;  bus.res_ready = 1'b1;
        bus2.A_in = '0; bus2.B_in = '0; bus2.valid_in = 1'b0; bus2.clear = 1'b0; bus2.res_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({bus.A_out, bus.B_out, bus.valid_out, bus.RES, bus.res_valid, bus.OVF} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {bus.A_out, bus.B_out, bus.valid_out, bus.RES, bus.res_valid, bus.OVF});
        end
        n_tests++;
        if ({bus2.A_out, bus2.B_out, bus2.valid_out, bus2.RES, bus2.res_valid, bus2.OVF} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs2: got %h, expected 0",
                     {bus2.A_out, bus2.B_out, bus2.valid_out, bus2.RES, bus2.res_valid, bus2.OVF});
        end
        rst = 1'b0;
    endtask

    task automatic test_forwarding();
        beat(8'h5A, 8'hC3);
        n_tests++;
        if (bus.A_out !== 8'h5A) begin n_fail++; $display("FAIL fwd_a: got %h, expected 5a", bus.A_out); end
        n_tests++;
        if (bus.B_out !== 8'hC3) begin n_fail++; $display("FAIL fwd_b: got %h, expected c3", bus.B_out); end
        n_tests++;
        if (bus.valid_out !== 1'b1) begin n_fail++; $display("FAIL fwd_valid: got %b, expected 1", bus.valid_out); end
        bus.valid_in = 1'b0;
        bus.A_in = '0;
        bus.B_in = '0;
        tick();
        n_tests++;
        if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL fwd_valid_drop: got %b, expected 0", bus.valid_out); end
        do_reset();
    endtask

    task automatic test_dot_product();
        logic [7:0] a_t [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
        logic [7:0] b_t [4] = '{8'd2, 8'd4, 8'd6, 8'd8};
        int cyc = 0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(a_t[i], b_t[i]);
            cyc++;
        end
        bus.valid_in = 1'b0;
        wait_result(30, cyc);
        n_tests++;
        if (cyc !== 6) begin n_fail++; $display("FAIL dot_latency: got %0d cycles, expected 6", cyc); end
        n_tests++;
        if (bus.RES !== 32'd100) begin n_fail++; $display("FAIL dot_res: got %0d, expected 100", bus.RES); end
        n_tests++;
        if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL dot_ovf: got %b, expected 0", bus.OVF); end
        tick();
        n_tests++;
        if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL dot_pulse: got %b, expected 0", bus.res_valid); end
    endtask

    task automatic test_bubbles();
        logic [7:0] a_t [4] = '{8'd1, 8'd3, 8'd5, 8'd7};
        logic [7:0] b_t [4] = '{8'd2, 8'd4, 8'd6, 8'd8};
        int cyc = 0;
        for (int i = 0; i < 4; i++) begin
            beat(a_t[i], b_t[i]);
            cyc++;
            if (i < 3) begin
                bus.valid_in = 1'b0;
                tick();
                cyc++;
            end
        end
        bus.valid_in = 1'b0;
        wait_result(30, cyc);
        n_tests++;
        if (cyc !== 9) begin n_fail++; $display("FAIL bubble_latency: got %0d cycles, expected 9", cyc); end
        n_tests++;
        if (bus.RES !== 32'd100) begin n_fail++; $display("FAIL bubble_res: got %0d, expected 100", bus.RES); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] a_t [8] = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd255, 8'd255, 8'd255, 8'd255};
        logic [7:0] b_t [8] = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd255, 8'd255, 8'd255, 8'd255};
        bus.res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat(a_t[i], b_t[i]);
            if (i == 5) begin
                n_tests++;
                if (bus.res_valid !== 1'b1 || bus.RES !== 32'd100 || bus.OVF !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_first: got valid=%b res=%0d ovf=%b, expected valid=1 res=100 ovf=0",
                             bus.res_valid, bus.RES, bus.OVF);
                end
            end
        end
        bus.valid_in = 1'b0;
        tick();
        tick();
        n_tests++;
        if (bus.RES !== 32'd260100) begin n_fail++; $display("FAIL bp_res: got %0d, expected 260100", bus.RES); end
        n_tests++;
        if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, expected 1", bus.res_valid); end
        n_tests++;
        if (bus.OVF !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b, expected 1", bus.OVF); end
        bus.res_ready = 1'b1;
        tick();
        n_tests++;
        if (bus.res_valid !== 1'b0 || bus.OVF !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain: got valid=%b ovf=%b, expected valid=0 ovf=1", bus.res_valid, bus.OVF);
        end
    endtask

    task automatic test_async_reset();
        beat(8'd9, 8'd9);
        bus.A_in = 8'd7;
        bus.B_in = 8'd7;
        n_tests++;
        if (bus.A_out !== 8'd9 || bus.OVF !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: got a_out=%0d ovf=%b, expected 9 and 1", bus.A_out, bus.OVF);
        end
        #3;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.A_out, bus.B_out, bus.valid_out, bus.RES, bus.res_valid, bus.OVF} !== '0) begin
            n_fail++;
            $display("FAIL areset_outputs: got %h, expected 0",
                     {bus.A_out, bus.B_out, bus.valid_out, bus.RES, bus.res_valid, bus.OVF});
        end
        bus.valid_in = 1'b0;
        bus.A_in = '0;
        bus.B_in = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_same_cycle_handshake();
        logic [7:0] a_t [8] = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd255, 8'd255, 8'd255, 8'd255};
        logic [7:0] b_t [8] = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd255, 8'd255, 8'd255, 8'd255};
        bus.res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat(a_t[i], b_t[i]);
        end
        bus.valid_in = 1'b0;
        tick();
        n_tests++;
        if (bus.res_valid !== 1'b1 || bus.RES !== 32'd100) begin
            n_fail++;
            $display("FAIL hs_pending: got valid=%b res=%0d, expected valid=1 res=100", bus.res_valid, bus.RES);
        end
        bus.res_ready = 1'b1;
        tick();
        n_tests++;
        if (bus.RES !== 32'd260100 || bus.res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hs_new: got valid=%b res=%0d, expected valid=1 res=260100", bus.res_valid, bus.RES);
        end
        n_tests++;
        if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL hs_ovf: got %b, expected 0", bus.OVF); end
        tick();
        n_tests++;
        if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL hs_drain: got %b, expected 0", bus.res_valid); end
    endtask

    task automatic test_clear();
        int cyc = 0;
        bit seen = 1'b0;
        bus.res_ready = 1'b1;
        beat(8'd9, 8'd9);
        beat(8'd9, 8'd9);
        bus.valid_in = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(8'd2, 8'd2);
            cyc++;
            if (bus.res_valid === 1'b1) seen = 1'b1;
        end
        bus.valid_in = 1'b0;
        wait_result(30, cyc);
        n_tests++;
        if (seen !== 1'b0 || cyc !== 6) begin
            n_fail++;
            $display("FAIL clr_timing: got early=%b cycles=%0d, expected early=0 cycles=6", seen, cyc);
        end
        n_tests++;
        if (bus.RES !== 32'd16) begin n_fail++; $display("FAIL clr_res: got %0d, expected 16", bus.RES); end
        for (int i = 0; i < 4; i++) begin
            beat(8'd3, 8'd3);
        end
        bus.valid_in = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (bus.res_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL clr_override: got result=%b, expected 0", seen); end
        n_tests++;
        if (bus.RES !== 32'd16) begin n_fail++; $display("FAIL clr_hold: got %0d, expected 16", bus.RES); end
    endtask

    task automatic test_wrap_or_saturate();
        int cyc = 2;
        bus2.res_ready = 1'b1;
        bus2.A_in = 8'd255;
        bus2.B_in = 8'd255;
        bus2.valid_in = 1'b1;
        tick();
        tick();
        bus2.valid_in = 1'b0;
        while (bus2.res_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (cyc !== 4) begin n_fail++; $display("FAIL k2_latency: got %0d cycles, expected 4", cyc); end
`ifdef SYSTOLIC_PE_SATURATE_EN
        n_tests++;
        if (bus2.RES !== 16'hFFFF) begin n_fail++; $display("FAIL sat_res: got %h, expected ffff", bus2.RES); end
        n_tests++;
        if (bus2.SAT !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %b, expected 1", bus2.SAT); end
`else
        n_tests++;
        if (bus2.RES !== 16'hFC02) begin n_fail++; $display("FAIL wrap_res: got %h, expected fc02", bus2.RES); end
`endif
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_dot_product();
        test_bubbles();
        test_backpressure();
        test_async_reset();
        test_same_cycle_handshake();
        test_clear();
        test_wrap_or_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
        $fatal(1);
    end
endmodule

// File: doc/systolic_pe.md
Name: systolic_pe

Overview:
- Output-stationary processing element for the systolic array; sits directly downstream of the Bam_cell array multiplier and consumes its product.
- Each cycle it forwards the A operand east and the B operand south, each with a one-cycle register.
- It multiplies A by B through an array multiplier built from Bam_cell, and accumulates K_LEN products into a partial sum.
- It presents the finished dot product through a valid/ready result port.

Parameters:
- DATA_W, 8, unsigned operand width in bits.
- ACC_W, 32, accumulator and result width in bits; must be at least 2*DATA_W.
- K_LEN, 16, number of valid products per dot product; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- A_in  in  DATA_W  operand arriving from the west neighbour.
- B_in  in  DATA_W  operand arriving from the north neighbour.
- valid_in  in  1  A_in/B_in pair is valid this cycle.
- clear  in  1  synchronous abort: discard the partial sum and the beat count.
- A_out  out  DATA_W  registered A_in, to the east neighbour.
- B_out  out  DATA_W  registered B_in, to the south neighbour.
- valid_out  out  1  registered valid_in, to the neighbours.
- RES  out  ACC_W  completed dot product.
- res_valid  out  1  RES holds an unconsumed result.
- res_ready  in  1  consumer accepts RES.
- OVF  out  1  sticky flag: a result was overwritten before it was consumed.

Behaviour:
- Reset (asynchronous, active-high): all registers and outputs go to 0; state = IDLE; count = 0.
- Forwarding: A_out, B_out and valid_out equal the previous cycle's A_in, B_in and valid_in, unconditionally.
  - Forwarding is unaffected by clear, the state machine and result backpressure.
- Pipeline stage 1: on valid_in, P = A_in*B_in (2*DATA_W bits, unsigned, zero-extended to ACC_W) is registered together with a p_valid bit.
- Pipeline stage 2: on p_valid, acc <= acc + P, and count increments.
  - Latency from the last valid_in beat to res_valid rising is 3 cycles.
- States:
  - IDLE (acc = 0, count = 0) -> ACC on the first p_valid.
  - ACC -> DONE when p_valid arrives and count == K_LEN-1. In that same cycle, RES <= acc + P, acc <= 0 and count <= 0.
  - DONE lasts one cycle, then goes to IDLE, or to ACC if p_valid is high in that cycle.
  - In DONE, a p_valid beat starts the next dot product: acc <= P, count <= 1.
- Result port:
  - res_valid is set in the DONE cycle.
  - It clears on any cycle where res_valid && res_ready.
  - RES holds its value until overwritten.
- Back-to-back completion:
  - If a new completion occurs while res_valid = 1 and res_ready = 0, RES is overwritten, res_valid stays 1 and OVF <= 1.
  - If res_ready = 1 in that same cycle, the handshake completes first: no OVF, and res_valid stays 1 for the new result.
- Wrap-around: acc and RES are modulo 2^ACC_W unless SATURATE_EN is defined.
- clear:
  - Forces acc = 0, count = 0, state = IDLE and drops p_valid.
  - clear overrides a simultaneous completion: no result is produced.
  - clear does not touch RES, res_valid or OVF.
- valid_in = 0 beats are bubbles: acc and count hold.
- K_LEN = 1: every valid beat produces a result.

Optional Feature:
- Macro: SYSTOLIC_PE_SATURATE_EN.
- Defined: the accumulate adder clamps at 2^ACC_W-1 instead of wrapping. The first clamp in a dot product sets a per-result sat bit, exported as output port SAT (1 bit). SAT is updated together with RES and cleared by reset.
- Undefined: modulo wrap; the SAT port does not exist.

Decomposition:
- Package systolic_pkg:
  - localparam defaults for DATA_W, ACC_W and K_LEN.
  - typedef enum logic [1:0] {IDLE, ACC, DONE} pe_state_t.
  - Function sat_add(a, b) used under the macro.
- Sub-module array_multiplier (DATA_W parameter):
  - DATA_W x DATA_W grid of Bam_cell instances, with a final ripple row.
  - Purely combinational; systolic_pe instantiates it once in front of the stage-1 register.

Test Plan:
- Forwarding: A_in=0x5A, B_in=0xC3, valid_in=1 for one cycle -> the next cycle A_out=0x5A, B_out=0xC3, valid_out=1; the cycle after, valid_out=0.
- Dot product, K_LEN=4: pairs (1,2), (3,4), (5,6), (7,8) on consecutive cycles, res_ready=1 -> res_valid pulses 3 cycles after the last beat, RES=100, OVF=0.
- Bubbles: the same 4 pairs with valid_in=0 gaps between them -> RES=100, delayed by the number of gaps.
- Backpressure: two back-to-back dot products, RES 100 then 4*255*255=260100, res_ready=0 -> RES=260100, res_valid=1, OVF=1; asserting res_ready drops res_valid the next cycle.
- Clear: clear=1 after 2 beats, then 4 new beats (2,2)x4 -> RES=16, with no result from the aborted run.
- Reset and saturation:
  - rst mid-accumulation -> all outputs 0 immediately (asynchronous).
  - With SYSTOLIC_PE_SATURATE_EN and ACC_W=16, K_LEN=2: (255,255),(255,255) -> RES=0xFFFF, SAT=1.
